// File: rtl/player_move_ctrl.sv
// Player movement controller: debounces four switches, moves the player one grid cell
// per press, and runs the PLAY/WIN/DEAD respawn FSM. Optional macro: PLAYER_AUTOREPEAT_EN.
module player_move_ctrl #(
    parameter int COLS            = 20,
    parameter int ROWS            = 15,
    parameter int SPAWN_X         = 10,
    parameter int SPAWN_Y         = 14,
    parameter int GOAL_ROW        = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 12500000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_player_up,
    input  logic       i_player_down,
    input  logic       i_player_left,
    input  logic       i_player_right,
    input  logic       i_hit,
    output logic [9:0] o_player_x,
    output logic [9:0] o_player_y,
    output logic       o_level_up,
    output logic [1:0] o_state
);

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_WIN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [9:0]        MAX_X     = 10'(COLS - 1);
    localparam logic [9:0]        MAX_Y     = 10'(ROWS - 1);
    localparam logic [9:0]        SP_X      = 10'(SPAWN_X);
    localparam logic [9:0]        SP_Y      = 10'(SPAWN_Y);
    localparam logic [9:0]        GOAL      = 10'(GOAL_ROW);

    // Bit order everywhere: [0] up, [1] down, [2] left, [3] right.
    logic [3:0]        raw;
    logic [3:0]        sync1;
    logic [3:0]        sync2;
    logic [3:0]        db_level;
    logic [3:0]        db_prev;
    logic [DB_W-1:0]   db_cnt [4];
    logic [3:0]        edge_req;
    logic [3:0]        move_req;

    logic [1:0]        state;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [9:0]        y_up;
    logic [9:0]        y_dn;
    logic              arrived;
    logic              level_up;
    logic [HOLD_W-1:0] hold_cnt;

    assign raw      = {i_player_right, i_player_left, i_player_down, i_player_up};
    assign edge_req = db_level & ~db_prev;
    assign y_up     = pos_y - 10'd1;
    assign y_dn     = pos_y + 10'd1;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The counter only advances while the synchronised input disagrees with the accepted level.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            db_level <= '0;
            db_prev  <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_prev <= db_level;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef PLAYER_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             one_dir;
    logic             rep_fire;

    assign one_dir  = $onehot(db_level);
    assign rep_fire = (state == ST_PLAY) && one_dir && (edge_req == 4'b0) && (rep_cnt == REP_LAST);
    assign move_req = edge_req | (rep_fire ? db_level : 4'b0);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rep_cnt <= '0;
        end else if ((state != ST_PLAY) || !one_dir || (edge_req != 4'b0) || rep_fire) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign move_req = edge_req;
`endif

    // A hit beats a pending win or move; 'arrived' marks that a move just landed on the goal row.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state    <= ST_PLAY;
            pos_x    <= SP_X;
            pos_y    <= SP_Y;
            arrived  <= 1'b0;
            level_up <= 1'b0;
            hold_cnt <= '0;
        end else begin
            level_up <= 1'b0;
            case (state)
                ST_PLAY: begin
                    if (i_hit) begin
                        state    <= ST_DEAD;
                        arrived  <= 1'b0;
                        hold_cnt <= '0;
                    end else if (arrived) begin
                        state    <= ST_WIN;
                        level_up <= 1'b1;
                        arrived  <= 1'b0;
                        hold_cnt <= '0;
                    end else if (move_req[0]) begin
                        if (pos_y != 10'd0) begin
                            pos_y   <= y_up;
                            arrived <= (y_up == GOAL);
                        end
                    end else if (move_req[1]) begin
                        if (pos_y != MAX_Y) begin
                            pos_y   <= y_dn;
                            arrived <= (y_dn == GOAL);
                        end
                    end else if (move_req[2]) begin
                        if (pos_x != 10'd0) begin
                            pos_x <= pos_x - 10'd1;
                        end
                    end else if (move_req[3]) begin
                        if (pos_x != MAX_X) begin
                            pos_x <= pos_x + 10'd1;
                        end
                    end
                end
                ST_WIN, ST_DEAD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_PLAY;
                        pos_x    <= SP_X;
                        pos_y    <= SP_Y;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_PLAY;
                end
            endcase
        end
    end

    assign o_player_x = pos_x;
    assign o_player_y = pos_y;
    assign o_level_up = level_up;
    assign o_state    = state;

endmodule
